// File: rtl/entity_slot_scheduler_if.sv
// Requester-side write port of the entity slot scheduler: request, target slot, word, ack.
interface entity_slot_scheduler_if #(
  parameter int NUM_REQ  = 4,
  parameter int ENTITY_W = 18
);
  logic [NUM_REQ-1:0]          req;
  logic [4*NUM_REQ-1:0]        req_slot;
  logic [ENTITY_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]          ack;

  modport master (output req, output req_slot, output req_data, input ack);
  modport slave  (input req, input req_slot, input req_data, output ack);
endinterface

// File: rtl/entity_slot_scheduler.sv
// Round-robin slot writes into a shadow table; shadow is copied to the PPU-facing
// active table one slot per cycle starting at the first vertical-blank line.
module entity_slot_scheduler #(
  parameter int                  NUM_REQ      = 4,
  parameter int                  NUM_SLOTS    = 14,
  parameter int                  ENTITY_W     = 18,
  parameter int                  VBLANK_LINE  = 480,
  parameter logic [ENTITY_W-1:0] BLANK_ENTITY = 18'h3F000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [9:0]                    counter_V,
  entity_slot_scheduler_if.slave        rq,
  output logic [ENTITY_W*NUM_SLOTS-1:0] slots,
  output logic                          busy,
  output logic                          commit_done
);
  localparam int         PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [4:0] SLOT_LIM = 5'(NUM_SLOTS);
  localparam logic [3:0] LAST_IDX = 4'(NUM_SLOTS - 1);
  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] COMMIT   = 1'b1;

  logic [0:0]                         state;
  logic [PTR_W-1:0]                   rr_ptr;
  logic [3:0]                         copy_idx;
  logic [9:0]                         prev_v;
  logic [NUM_REQ-1:0]                 ack_q;
  logic [NUM_SLOTS-1:0][ENTITY_W-1:0] shadow;
  logic [NUM_SLOTS-1:0][ENTITY_W-1:0] active;

  logic                trigger;
  logic [NUM_REQ-1:0]  elig;
  logic                grant_vld;
  logic [PTR_W-1:0]    grant_idx;
  logic [3:0]          grant_slot;
  logic [ENTITY_W-1:0] grant_data;

  assign trigger = (counter_V == 10'(VBLANK_LINE)) && (prev_v != 10'(VBLANK_LINE));
  // A requester acked this cycle still shows req high; mask it so it is not regranted.
  assign elig    = rq.req & ~ack_q;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int o = 0; o < NUM_REQ; o++) begin
      if (!grant_vld && elig[(int'(rr_ptr) + o) % NUM_REQ]) begin
        grant_vld = 1'b1;
        grant_idx = PTR_W'((int'(rr_ptr) + o) % NUM_REQ);
      end
    end
  end

  assign grant_slot  = rq.req_slot[4*grant_idx +: 4];
  assign grant_data  = rq.req_data[ENTITY_W*grant_idx +: ENTITY_W];
  assign rq.ack      = ack_q;
  assign slots       = active;
  assign busy        = (state == COMMIT);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      copy_idx    <= '0;
      prev_v      <= '0;
      ack_q       <= '0;
      commit_done <= 1'b0;
      shadow      <= {NUM_SLOTS{BLANK_ENTITY}};
      active      <= {NUM_SLOTS{BLANK_ENTITY}};
    end else begin
      prev_v      <= counter_V;
      ack_q       <= '0;
      commit_done <= 1'b0;
      case (state)
        IDLE: begin
          // Trigger beats a pending request; the request simply waits out the commit.
          if (trigger) begin
            state    <= COMMIT;
            copy_idx <= '0;
          end else if (grant_vld) begin
            ack_q[grant_idx] <= 1'b1;
            rr_ptr           <= PTR_W'((int'(grant_idx) + 1) % NUM_REQ);
            if ({1'b0, grant_slot} < SLOT_LIM)
              shadow[grant_slot] <= grant_data;
          end
        end
        default: begin
          active[copy_idx] <= shadow[copy_idx];
          if (copy_idx == LAST_IDX) begin
            state       <= IDLE;
            copy_idx    <= '0;
            commit_done <= 1'b1;
          end else begin
            copy_idx <= copy_idx + 4'd1;
          end
        end
      endcase
    end
  end
endmodule

// File: doc/entity_slot_scheduler.md
# entity_slot_scheduler

Owns the entity slot table that feeds the picture processing unit's 14 entity/dragon slot inputs. It round-robin arbitrates slot-write requests from game-logic requesters (player, sword, sheep, dragon segments) into a shadow table. Once per frame, at the start of vertical blank, it copies the shadow table into the active table. The PPU therefore never sees a half-updated frame.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters.
- NUM_SLOTS, 14, number of entity slots (fixed ≤ 16; index width 4).
- ENTITY_W, 18, entity word width.
- VBLANK_LINE, 480, counter_V value marking the first blanking line.
- BLANK_ENTITY, 18'h3F000, empty-slot word (ID field 4'b1111).

Ports:
- clk  in  1  25 MHz pixel clock.
- reset  in  1  reset, synchronous, active-low.
- counter_V  in  10  current VGA line.
- req  in  NUM_REQ  per-requester write request; held until acked.
- req_slot  in  4*NUM_REQ  target slot index; requester i uses [4i+:4].
- req_data  in  ENTITY_W*NUM_REQ  entity word; requester i uses [ENTITY_W*i+:ENTITY_W].
- ack  out  NUM_REQ  one-cycle, one-hot acknowledge.
- slots  out  ENTITY_W*NUM_SLOTS  active table; slot k is [ENTITY_W*k+:ENTITY_W], maps to PPU slot inputs.
- busy  out  1  high while in COMMIT.
- commit_done  out  1  one-cycle pulse after the last slot is copied.

## Operation
- State machine has two states:
  - IDLE: accept writes.
  - COMMIT: copy shadow → active; no grants.
- Trigger:
  - prev_v is a register that samples counter_V every cycle.
  - trigger = (counter_V == VBLANK_LINE) && (prev_v != VBLANK_LINE).
  - A trigger in IDLE moves to COMMIT with copy_idx = 0.
  - A trigger in COMMIT is ignored.
- Arbitration in IDLE:
  - Eligible requesters: req[i] && !ack[i]. A requester acked this cycle is masked so its still-high req is not regranted.
  - Round-robin search starts at rr_ptr, ascending with wrap.
  - On grant of requester g at an edge:
    - if req_slot < NUM_SLOTS, shadow[req_slot] <= req_data;
    - ack[g] <= 1 for the next cycle;
    - rr_ptr <= (g+1) mod NUM_REQ.
  - At most one grant per cycle.
- Invalid slot (req_slot ≥ NUM_SLOTS): acked normally, no write.
- If trigger and a pending request coincide in the same IDLE cycle, the trigger wins. No grant is made, and the request stays pending through COMMIT.
- COMMIT:
  - Each edge: active[copy_idx] <= shadow[copy_idx]; copy_idx++.
  - On the edge that copies slot NUM_SLOTS-1: go to IDLE and set commit_done <= 1 for one cycle.
- Shadow contents persist across frames. Requesters only rewrite slots that changed.
- slots is driven directly from the active registers.

## Timing
- Reset (reset low at an edge) sets:
  - all shadow and active entries to BLANK_ENTITY;
  - ack = 0, busy = 0, commit_done = 0;
  - state IDLE, rr_ptr = 0, copy_idx = 0, prev_v = 0.
- A reset mid-COMMIT abandons the copy. The active table is fully blank the next cycle.
- Write latency:
  - req sampled at edge E: shadow updated and ack high in cycle E+1.
  - The requester may present a new req/slot/data in cycle E+1; it is eligible from E+2.
- Commit latency:
  - Trigger edge E0 sets busy = 1.
  - Slot k appears on slots after edge E(k+1).
  - busy falls and commit_done pulses after edge E(NUM_SLOTS), i.e. 14 cycles of COMMIT.
- Writes granted at edge E0 or earlier are visible in that frame's commit. Later writes are visible next frame.
- Worst-case grant wait in IDLE is NUM_REQ-1 cycles.

## Test plan
- Reset: hold reset=0 for 2 cycles with all req high.
  - Every slot reads 18'h3F000, ack=0, busy=0.
  - The first grant after release goes to requester 0.
- Single write + commit: requester 1 writes slot 3 = 18'h0A5C7.
  - ack[1] pulses once; slots[3] stays blank.
  - Step counter_V 479→480: busy rises, slots[3] = 18'h0A5C7 after the 4th COMMIT edge, commit_done pulses after the 14th.
- Contention: all 4 req high continuously, each with a distinct slot.
  - Grants go 0,1,2,3,0, one per cycle, with no duplicate ack while req is held.
- Write during commit: assert req[2] (slot 5) one cycle after the trigger.
  - No ack while busy; ack[2] in the first cycle after COMMIT ends.
  - slots[5] unchanged until the next frame's commit.
- Invalid slot: req[0] with slot 15.
  - ack[0] pulses and no slot changes after the following commit.
  - Holding counter_V at 480 for many cycles produces only one commit.
- Reset mid-commit: assert reset at COMMIT cycle 6 after slots 0–5 were copied as non-blank.
  - All slots are blank next cycle, busy=0, no commit_done.
